// File: rtl/adat_rx_pkg.sv
// adat_rx_pkg: shared types and widths for the ADAT receive lock path
package adat_rx_pkg;

    localparam int FRAME_TIME_W = 12;
    localparam int SYNC_CNT_W   = 13;

    typedef enum logic [2:0] {
        ST_SEARCH  = 3'd0,
        ST_MEASURE = 3'd1,
        ST_VERIFY  = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_RESYNC  = 3'd4
    } lock_state_e;

endpackage

// File: rtl/adat_rx_watchdog.sv
// adat_rx_watchdog: saturating edge/sync age counters with timeout compares
module adat_rx_watchdog
    import adat_rx_pkg::*;
#(
    parameter int EDGE_TIMEOUT = 1023
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_edge,
    input  logic                  i_sync,
    input  logic [SYNC_CNT_W-1:0] i_sync_limit,
    output logic                  o_edge_timeout,
    output logic                  o_sync_timeout
);

    localparam int EW = $clog2(EDGE_TIMEOUT + 1);

    logic [EW-1:0]         r_edge_cnt;
    logic [SYNC_CNT_W-1:0] r_sync_cnt;

    // a sync is itself an edge, so it restarts both ages
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_edge_cnt <= '0;
            r_sync_cnt <= '0;
        end else begin
            r_edge_cnt <= (i_edge || i_sync) ? '0 :
                          o_edge_timeout ? r_edge_cnt : r_edge_cnt + 1'b1;
            r_sync_cnt <= i_sync ? '0 : (&r_sync_cnt) ? r_sync_cnt : r_sync_cnt + 1'b1;
        end
    end

    assign o_edge_timeout = r_edge_cnt == EW'(EDGE_TIMEOUT);
    assign o_sync_timeout = r_sync_cnt > i_sync_limit;

endmodule

// File: rtl/adat_rx_lock_controller.sv
// adat_rx_lock_controller: ADAT receive lock FSM; gates the decoder, marks frames,
// and pulses the tracker reset when lock is lost
module adat_rx_lock_controller
    import adat_rx_pkg::*;
#(
    parameter int LOCK_FRAMES    = 4,
    parameter int FRAME_TOL      = 8,
    parameter int EDGE_TIMEOUT   = 1023,
    parameter int TRK_RST_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_edge,
    input  logic                    i_sync,
    input  logic [FRAME_TIME_W-1:0] i_frame_time,
    output logic                    o_locked,
    output logic                    o_decoder_en,
    output logic                    o_frame_start,
    output logic                    o_lost,
    output logic                    o_tracker_rst,
    output logic [FRAME_TIME_W-1:0] o_frame_ref,
    output logic [2:0]              o_state
);

    lock_state_e           r_state;
    logic [3:0]            r_match_cnt;
    logic [2:0]            r_rst_cnt;
    logic                  w_edge_timeout;
    logic                  w_sync_timeout;
    logic                  w_in_tol;
    logic                  w_loss;
    logic [SYNC_CNT_W-1:0] w_sync_limit;
    logic [SYNC_CNT_W-1:0] w_diff;
    logic [SYNC_CNT_W-1:0] w_abs;

    // MEASURE gives up at 4095 idle cycles; otherwise allow 1.5 reference frames
    assign w_sync_limit = (r_state == ST_MEASURE) ? 13'd4094 :
                          {1'b0, o_frame_ref} + {2'b0, o_frame_ref[FRAME_TIME_W-1:1]};
    assign w_diff       = {1'b0, i_frame_time} - {1'b0, o_frame_ref};
    assign w_abs        = w_diff[SYNC_CNT_W-1] ? -w_diff : w_diff;
    assign w_in_tol     = w_abs <= SYNC_CNT_W'(FRAME_TOL);
    assign w_loss       = (r_state == ST_VERIFY || r_state == ST_LOCKED) &&
                          (i_sync ? (r_state == ST_LOCKED && !w_in_tol) :
                                    (w_edge_timeout || w_sync_timeout));
    assign o_state      = r_state;

    adat_rx_watchdog #(
        .EDGE_TIMEOUT(EDGE_TIMEOUT)
    ) u_watchdog (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_edge         (i_edge),
        .i_sync         (i_sync),
        .i_sync_limit   (w_sync_limit),
        .o_edge_timeout (w_edge_timeout),
        .o_sync_timeout (w_sync_timeout)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= ST_SEARCH;
            r_match_cnt   <= '0;
            r_rst_cnt     <= '0;
            o_locked      <= 1'b0;
            o_decoder_en  <= 1'b0;
            o_frame_start <= 1'b0;
            o_lost        <= 1'b0;
            o_tracker_rst <= 1'b1;
            o_frame_ref   <= '0;
        end else begin
            o_frame_start <= i_sync && r_state == ST_LOCKED;
            o_lost        <= w_loss;
            if (w_loss) begin
                r_state       <= ST_RESYNC;
                r_match_cnt   <= '0;
                r_rst_cnt     <= '0;
                o_locked      <= 1'b0;
                o_decoder_en  <= 1'b0;
                o_tracker_rst <= 1'b0;
            end else begin
                case (r_state)
                    ST_SEARCH:  if (i_sync) r_state <= ST_MEASURE;
                    ST_MEASURE: begin
                        if (i_sync) begin
                            o_frame_ref <= i_frame_time;
                            r_match_cnt <= '0;
                            r_state     <= ST_VERIFY;
                        end else if (w_sync_timeout) begin
                            r_state <= ST_SEARCH;
                        end
                    end
                    ST_VERIFY: begin
                        if (i_sync) begin
                            o_frame_ref <= i_frame_time;
                            r_match_cnt <= w_in_tol ? r_match_cnt + 1'b1 : '0;
                            if (w_in_tol && r_match_cnt == 4'(LOCK_FRAMES - 1)) begin
                                r_state      <= ST_LOCKED;
                                o_locked     <= 1'b1;
                                o_decoder_en <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED:  if (i_sync) o_frame_ref <= i_frame_time;
                    ST_RESYNC: begin
                        if (r_rst_cnt == 3'(TRK_RST_CYCLES - 1)) begin
                            o_tracker_rst <= 1'b1;
                            r_state       <= ST_SEARCH;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 3'd1;
                        end
                    end
                    default:    r_state <= ST_SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adat_rx_lock_controller.sv
// tb_adat_rx_lock_controller: directed stimulus, timestamp-based reference model
// compared every cycle, plus literal pins on key moments
module tb_adat_rx_lock_controller;

    localparam int M_SEARCH  = 0;
    localparam int M_MEASURE = 1;
    localparam int M_VERIFY  = 2;
    localparam int M_LOCKED  = 3;
    localparam int M_RESYNC  = 4;
    localparam int LOCK_N    = 4;
    localparam int TOL       = 8;
    localparam int EDGE_TO   = 1023;
    localparam int RST_LEN   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_edge = 1'b0;
    logic        i_sync = 1'b0;
    logic [11:0] i_frame_time = '0;
    logic        o_locked, o_decoder_en, o_frame_start, o_lost, o_tracker_rst;
    logic [11:0] o_frame_ref;
    logic [2:0]  o_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int cyc = 0, last_e = 0, last_s = 0;
    int m_mode, m_ref, m_match, m_left;
    bit p_fs, p_lost;
    int e_state = 0, e_ref = 0;
    bit e_locked = 0, e_dec = 0, e_fs = 0, e_lost = 0, e_trk = 1;

    always #5 clk = ~clk;

    adat_rx_lock_controller dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .i_edge        (i_edge),
        .i_sync        (i_sync),
        .i_frame_time  (i_frame_time),
        .o_locked      (o_locked),
        .o_decoder_en  (o_decoder_en),
        .o_frame_start (o_frame_start),
        .o_lost        (o_lost),
        .o_tracker_rst (o_tracker_rst),
        .o_frame_ref   (o_frame_ref),
        .o_state       (o_state)
    );

    task automatic commit();
        e_state  = m_mode;
        e_ref    = m_ref;
        e_locked = (m_mode == M_LOCKED);
        e_dec    = (m_mode == M_LOCKED);
        e_trk    = (m_mode != M_RESYNC);
        e_fs     = p_fs;
        e_lost   = p_lost;
    endtask

    task automatic model_reset();
        m_mode = M_SEARCH; m_ref = 0; m_match = 0; m_left = 0;
        p_fs = 0; p_lost = 0;
        last_e = cyc; last_s = cyc;
        commit();
    endtask

    // ages are cycles since the last clearing event, as seen at this clock edge
    task automatic model_step();
        int ea, sa, d;
        bit lose;
        cyc++;
        ea = cyc - last_e - 1;
        sa = cyc - last_s - 1;
        d  = int'(i_frame_time) - m_ref;
        if (d < 0) d = -d;
        p_fs = 0; p_lost = 0; lose = 0;
        if (m_mode == M_SEARCH) begin
            if (i_sync) m_mode = M_MEASURE;
        end else if (m_mode == M_MEASURE) begin
            if (i_sync) begin m_ref = int'(i_frame_time); m_match = 0; m_mode = M_VERIFY; end
            else if (sa >= 4095) m_mode = M_SEARCH;
        end else if (m_mode == M_RESYNC) begin
            m_left--;
            if (m_left == 0) m_mode = M_SEARCH;
        end else if (i_sync) begin
            if (m_mode == M_LOCKED) begin
                p_fs = 1;
                if (d <= TOL) m_ref = int'(i_frame_time); else lose = 1;
            end else begin
                m_ref = int'(i_frame_time);
                m_match = (d <= TOL) ? m_match + 1 : 0;
                if (m_match == LOCK_N) m_mode = M_LOCKED;
            end
        end else begin
            lose = (ea >= EDGE_TO) || (sa > m_ref + m_ref / 2);
        end
        if (lose) begin p_lost = 1; m_mode = M_RESYNC; m_left = RST_LEN; m_match = 0; end
        if (i_edge || i_sync) last_e = cyc;
        if (i_sync) last_s = cyc;
    endtask

    task automatic step(input bit e, input bit s, input int ft);
        i_edge = e; i_sync = s; i_frame_time = 12'(ft);
        model_step();
        @(posedge clk); #1;
        commit();
        i_edge = 0; i_sync = 0;
    endtask

    task automatic frames(input int count, input int ft_a, input int ft_b);
        for (int f = 0; f < count; f++)
            for (int c = 0; c < 1000; c++)
                step(c % 20 == 19, c == 999, (f % 2 == 0) ? ft_a : ft_b);
    endtask

    task automatic do_reset();
        rst_n = 0; i_edge = 0; i_sync = 0; i_frame_time = '0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic pin(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if ({o_locked, o_decoder_en, o_frame_start, o_lost, o_tracker_rst, o_frame_ref, o_state} !==
                {e_locked, e_dec, e_fs, e_lost, e_trk, 12'(e_ref), 3'(e_state)}) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t: dut st=%0d lk=%b de=%b fs=%b lost=%b trk=%b ref=%0d, model st=%0d lk=%b de=%b fs=%b lost=%b trk=%b ref=%0d",
                         $time, o_state, o_locked, o_decoder_en, o_frame_start, o_lost, o_tracker_rst, o_frame_ref,
                         e_state, e_locked, e_dec, e_fs, e_lost, e_trk, e_ref);
            end
        end
    end

    initial begin
        int k;
        #1;
        do_reset();
        chk_en = 1;
        pin("reset_state", int'(o_state), 0);
        pin("reset_trk", int'(o_tracker_rst), 1);
        pin("reset_ref", int'(o_frame_ref), 0);
        pin("reset_locked", int'(o_locked), 0);

        frames(1, 1000, 1000);
        pin("acq_measure", int'(o_state), 1);
        frames(1, 1000, 1000);
        pin("acq_verify", int'(o_state), 2);
        pin("acq_ref", int'(o_frame_ref), 1000);
        frames(3, 1000, 1000);
        pin("acq_3match", int'(o_locked), 0);
        frames(1, 1000, 1000);
        pin("acq_locked", int'(o_locked), 1);
        pin("acq_dec_en", int'(o_decoder_en), 1);
        pin("acq_no_fs_on_lock", int'(o_frame_start), 0);
        frames(1, 1000, 1000);
        pin("acq_first_fs", int'(o_frame_start), 1);

        frames(6, 1004, 996);
        pin("jitter_locked", int'(o_locked), 1);
        pin("jitter_ref", int'(o_frame_ref), 996);

        frames(1, 1020, 1020);
        pin("oot_lost", int'(o_lost), 1);
        pin("oot_locked", int'(o_locked), 0);
        pin("oot_trk", int'(o_tracker_rst), 0);
        pin("oot_ref_held", int'(o_frame_ref), 996);
        step(0, 0, 0);
        pin("oot_lost_pulse", int'(o_lost), 0);
        pin("oot_trk2", int'(o_tracker_rst), 0);
        step(0, 0, 0);
        pin("oot_trk_release", int'(o_tracker_rst), 1);
        pin("oot_search", int'(o_state), 0);

        frames(6, 1000, 1000);
        pin("eto_relock", int'(o_locked), 1);
        k = 0;
        while (!o_lost && k < 2000) begin step(0, 0, 0); k++; end
        pin("eto_delay", k, 1024);
        step(0, 0, 0); step(0, 0, 0);
        pin("eto_search", int'(o_state), 0);

        frames(6, 1000, 1000);
        k = 0;
        while (!o_lost && k < 3000) begin step(k % 20 == 19, 0, 0); k++; end
        pin("sto_delay", k, 1502);
        step(0, 0, 0); step(0, 0, 0);

        frames(6, 1000, 1000);
        for (int j = 1; j < 1502; j++) step(j % 20 == 0, 0, 0);
        step(1, 1, 1005);
        pin("coinc_fs", int'(o_frame_start), 1);
        pin("coinc_no_lost", int'(o_lost), 0);
        pin("coinc_ref", int'(o_frame_ref), 1005);
        step(0, 0, 0);
        pin("coinc_locked", int'(o_locked), 1);

        frames(1, 1020, 1020);
        step(0, 0, 0);
        pin("mid_rst_trk_low", int'(o_tracker_rst), 0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        pin("async_trk", int'(o_tracker_rst), 1);
        pin("async_state", int'(o_state), 0);
        @(posedge clk); #1;
        rst_n = 1;

        frames(2, 1000, 1000);
        frames(3, 1000, 1000);
        pin("ver_3match", int'(o_state), 2);
        frames(1, 1100, 1100);
        pin("ver_oot_state", int'(o_state), 2);
        pin("ver_oot_ref", int'(o_frame_ref), 1100);
        pin("ver_oot_nolost", int'(o_lost), 0);
        frames(3, 1100, 1100);
        pin("ver_count_reset", int'(o_state), 2);
        frames(1, 1109, 1109);
        pin("ver_tol9_state", int'(o_state), 2);
        frames(3, 1109, 1109);
        pin("ver_tol9_restart", int'(o_state), 2);
        frames(1, 1109, 1109);
        pin("ver_lock", int'(o_state), 3);

        do_reset();
        step(1, 1, 1000);
        pin("mto_measure", int'(o_state), 1);
        for (int j = 0; j < 4095; j++) step(0, 0, 0);
        pin("mto_hold", int'(o_state), 1);
        step(0, 0, 0);
        pin("mto_search", int'(o_state), 0);
        pin("mto_nolost", int'(o_lost), 0);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
